// File: rtl/block_mover.sv
// block_mover: moves one XDIM x YDIM sprite around the VGA adapter framebuffer.
// The sprite is drawn and erased one pixel per cycle through x_out/y_out/colour_out/plot.
// It steps by STEP pixels in the latched direction every TICK cycles.
// Optional feature: define BLOCK_MOVER_WRAP_EN to wrap the sprite around the screen edges
// instead of clamping it at the walls.
module block_mover #(
  parameter int unsigned XSCREEN   = 160,
  parameter int unsigned YSCREEN   = 120,
  parameter int unsigned XDIM      = 10,
  parameter int unsigned YDIM      = 10,
  parameter int unsigned STEP      = 1,
  parameter int unsigned TICK      = 1000000,
  parameter int unsigned X0        = 39,
  parameter int unsigned Y0        = 59,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic [3:0] dir_req,
  input  logic [2:0] fg_colour,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y,
  output logic [1:0] dir,
  output logic       moving,
  output logic       wall_hit,
  output logic       busy
);

  localparam int unsigned TW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);

  localparam logic [7:0] XLAST = 8'(XDIM - 1);
  localparam logic [6:0] YLAST = 7'(YDIM - 1);
  localparam logic [7:0] X0_V  = 8'(X0);
  localparam logic [6:0] Y0_V  = 7'(Y0);
  localparam logic [8:0] XSCR9 = 9'(XSCREEN);
  localparam logic [7:0] YSCR8 = 8'(YSCREEN);

  // Ten bits so that pos + STEP can never overflow before the edge test.
  localparam logic signed [9:0] STEP_S = 10'(STEP);
`ifdef BLOCK_MOVER_WRAP_EN
  localparam logic signed [9:0] XSCR_S = 10'(XSCREEN);
  localparam logic signed [9:0] YSCR_S = 10'(YSCREEN);
`else
  localparam logic signed [9:0] XMAX_S = 10'(XSCREEN - XDIM);
  localparam logic signed [9:0] YMAX_S = 10'(YSCREEN - YDIM);
`endif

  typedef enum logic [2:0] {StIdle, StDraw, StWait, StErase, StMove} state_e;

  state_e        state_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick_pending_q;
  logic [7:0]    xc_q;
  logic [6:0]    yc_q;

  logic       tick;
  logic [1:0] req_dir;
  logic       accept;
  logic       last_px;
  logic [7:0] nxc;
  logic [6:0] nyc;
  logic [7:0] next_x;
  logic [6:0] next_y;
  logic       hit;

  // Pixel coordinate from a base position and scan offset, folded back onto the screen.
  function automatic logic [7:0] pix_x(input logic [7:0] base, input logic [7:0] off);
    logic [8:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= XSCR9) sum = sum - XSCR9;
    return sum[7:0];
  endfunction

  function automatic logic [6:0] pix_y(input logic [6:0] base, input logic [6:0] off);
    logic [7:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= YSCR8) sum = sum - YSCR8;
    return sum[6:0];
  endfunction

  assign tick = (tick_cnt_q == TICK_LAST);
  assign busy = (state_q == StDraw) || (state_q == StErase) || (state_q == StMove);

  // Priority-decode the direction request and drop an exact reversal while moving.
  always_comb begin
    req_dir = 2'd0;
    if (dir_req[0])      req_dir = 2'd0;
    else if (dir_req[1]) req_dir = 2'd1;
    else if (dir_req[2]) req_dir = 2'd2;
    else if (dir_req[3]) req_dir = 2'd3;
    // Codes are arranged so that the reverse of d is ~d.
    accept = (|dir_req) && !(moving && (req_dir == ~dir));
  end

  // Row-major scan successor and end-of-scan detect.
  always_comb begin
    last_px = (xc_q == XLAST) && (yc_q == YLAST);
    if (xc_q == XLAST) begin
      nxc = 8'd0;
      nyc = yc_q + 1'b1;
    end else begin
      nxc = xc_q + 1'b1;
      nyc = yc_q;
    end
  end

  // Candidate position after one step, with edge handling.
  always_comb begin
    logic signed [9:0] cur_x, cur_y, nx, ny;
    cur_x = signed'({2'b00, pos_x});
    cur_y = signed'({3'b000, pos_y});
    nx    = cur_x;
    ny    = cur_y;
    hit   = 1'b0;
    unique case (dir)
      2'd0: nx = cur_x + STEP_S;
      2'd1: ny = cur_y + STEP_S;
      2'd2: ny = cur_y - STEP_S;
      2'd3: nx = cur_x - STEP_S;
    endcase
`ifdef BLOCK_MOVER_WRAP_EN
    if (nx >= XSCR_S)  nx = nx - XSCR_S;
    else if (nx[9])    nx = nx + XSCR_S;
    if (ny >= YSCR_S)  ny = ny - YSCR_S;
    else if (ny[9])    ny = ny + YSCR_S;
`else
    if (nx > XMAX_S) begin
      if (cur_x >= XMAX_S) begin
        nx  = cur_x;
        hit = 1'b1;
      end else begin
        nx  = XMAX_S;
      end
    end else if (nx[9]) begin
      if (cur_x == 10'sd0) hit = 1'b1;
      nx = 10'sd0;
    end
    if (ny > YMAX_S) begin
      if (cur_y >= YMAX_S) begin
        ny  = cur_y;
        hit = 1'b1;
      end else begin
        ny  = YMAX_S;
      end
    end else if (ny[9]) begin
      if (cur_y == 10'sd0) hit = 1'b1;
      ny = 10'sd0;
    end
`endif
    next_x = nx[7:0];
    next_y = ny[6:0];
  end

  // Main FSM: tick counter, direction latch, scan and move, all with registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q        <= StIdle;
      tick_cnt_q     <= '0;
      tick_pending_q <= 1'b0;
      xc_q           <= 8'd0;
      yc_q           <= 7'd0;
      pos_x          <= X0_V;
      pos_y          <= Y0_V;
      dir            <= 2'd0;
      moving         <= 1'b0;
      wall_hit       <= 1'b0;
      plot           <= 1'b0;
      x_out          <= 8'd0;
      y_out          <= 7'd0;
      colour_out     <= 3'd0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      if (tick && (state_q != StWait)) tick_pending_q <= 1'b1;

      if (start) begin
        // Abandon any scan in progress; leftover pixels are not cleaned up.
        state_q    <= StDraw;
        pos_x      <= X0_V;
        pos_y      <= Y0_V;
        wall_hit   <= 1'b0;
        moving     <= 1'b0;
        xc_q       <= 8'd0;
        yc_q       <= 7'd0;
        plot       <= 1'b1;
        x_out      <= pix_x(X0_V, 8'd0);
        y_out      <= pix_y(Y0_V, 7'd0);
        colour_out <= fg_colour;
      end else begin
        if ((state_q != StIdle) && accept) begin
          dir    <= req_dir;
          moving <= 1'b1;
        end

        case (state_q)
          StIdle: begin
            plot <= 1'b0;
          end

          StDraw, StErase: begin
            if (last_px) begin
              plot    <= 1'b0;
              state_q <= (state_q == StDraw) ? StWait : StMove;
            end else begin
              xc_q       <= nxc;
              yc_q       <= nyc;
              plot       <= 1'b1;
              x_out      <= pix_x(pos_x, nxc);
              y_out      <= pix_y(pos_y, nyc);
              colour_out <= (state_q == StDraw) ? fg_colour : BG_COLOUR;
            end
          end

          StWait: begin
            plot <= 1'b0;
            if ((tick || tick_pending_q) && moving) begin
              state_q        <= StErase;
              tick_pending_q <= 1'b0;
              xc_q           <= 8'd0;
              yc_q           <= 7'd0;
              plot           <= 1'b1;
              x_out          <= pix_x(pos_x, 8'd0);
              y_out          <= pix_y(pos_y, 7'd0);
              colour_out     <= BG_COLOUR;
            end
          end

          StMove: begin
            // First redraw pixel goes out in the same cycle the position updates.
            pos_x      <= next_x;
            pos_y      <= next_y;
            if (hit) wall_hit <= 1'b1;
            state_q    <= StDraw;
            xc_q       <= 8'd0;
            yc_q       <= 7'd0;
            plot       <= 1'b1;
            x_out      <= pix_x(next_x, 8'd0);
            y_out      <= pix_y(next_y, 7'd0);
            colour_out <= fg_colour;
          end

          default: begin
            state_q <= StIdle;
            plot    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_block_mover.sv
// Directed bench for block_mover: two instances share the clock and reset.
// Instance a exercises drawing, moving, reversal rejection, abort and reset;
// instance b exercises the right-hand screen edge (clamp, or wrap with BLOCK_MOVER_WRAP_EN).
module tb_block_mover;

`ifdef BLOCK_MOVER_WRAP_EN
  localparam int unsigned BX0 = 159, BSTEP = 1, BXP2 = 0, BX1 = 0, BX1P = 1, BX2 = 1, BHIT = 0;
`else
  localparam int unsigned BX0 = 157, BSTEP = 2, BXP2 = 158, BX1 = 158, BX1P = 159, BX2 = 158;
  localparam int unsigned BHIT = 1;
`endif

  logic       Clock, Reset;
  logic       start_a, start_b;
  logic [3:0] dir_req_a, dir_req_b;
  logic [2:0] fg_colour;

  logic [7:0] x_a, x_b, pos_x_a, pos_x_b;
  logic [6:0] y_a, y_b, pos_y_a, pos_y_b;
  logic [2:0] colour_a, colour_b;
  logic [1:0] dir_a, dir_b;
  logic       plot_a, plot_b, moving_a, moving_b, wall_a, wall_b, busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  block_mover #(
    .XDIM(2), .YDIM(2), .STEP(1), .TICK(4), .X0(39), .Y0(59)
  ) dut_a (
    .Clock(Clock), .Reset(Reset), .start(start_a), .dir_req(dir_req_a), .fg_colour(fg_colour),
    .x_out(x_a), .y_out(y_a), .colour_out(colour_a), .plot(plot_a),
    .pos_x(pos_x_a), .pos_y(pos_y_a), .dir(dir_a), .moving(moving_a), .wall_hit(wall_a),
    .busy(busy_a)
  );

  block_mover #(
    .XDIM(2), .YDIM(2), .STEP(BSTEP), .TICK(4), .X0(BX0), .Y0(59)
  ) dut_b (
    .Clock(Clock), .Reset(Reset), .start(start_b), .dir_req(dir_req_b), .fg_colour(fg_colour),
    .x_out(x_b), .y_out(y_b), .colour_out(colour_b), .plot(plot_b),
    .pos_x(pos_x_b), .pos_y(pos_y_b), .dir(dir_b), .moving(moving_b), .wall_hit(wall_b),
    .busy(busy_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Step until the chosen instance plots a pixel of the given colour, bounded.
  task automatic wait_pix(input bit use_b, input logic [2:0] col, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (use_b ? (plot_b && colour_b == col) : (plot_a && colour_a == col)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check(tag, found, 1);
  endtask

  initial begin
    Reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    dir_req_a = 4'd0; dir_req_b = 4'd0; fg_colour = 3'd5;
    repeat (3) step();

    check("rst_plot", plot_a, 0);
    check("rst_x", x_a, 0);
    check("rst_y", y_a, 0);
    check("rst_col", colour_a, 0);
    check("rst_pos_x", pos_x_a, 39);
    check("rst_pos_y", pos_y_a, 59);
    check("rst_dir", dir_a, 0);
    check("rst_moving", moving_a, 0);
    check("rst_wall", wall_a, 0);
    check("rst_busy", busy_a, 0);

    Reset = 1'b0;
    step();

    // Initial draw at (39,59), one cycle after start.
    start_a = 1'b1; step(); start_a = 1'b0;
    check("d0_plot", plot_a, 1);
    check("d0_x", x_a, 39);
    check("d0_y", y_a, 59);
    check("d0_col", colour_a, 5);
    check("d0_busy", busy_a, 1);
    step(); check("d1_x", x_a, 40); check("d1_y", y_a, 59);
    step(); check("d2_x", x_a, 39); check("d2_y", y_a, 60);
    step(); check("d3_x", x_a, 40); check("d3_y", y_a, 60); check("d3_plot", plot_a, 1);
    step(); check("wait_plot", plot_a, 0); check("wait_busy", busy_a, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("still_plot", plot_a, 0);
    end
    check("still_pos_x", pos_x_a, 39);
    check("still_moving", moving_a, 0);

    // Move right: erase in background colour, move, redraw one pixel to the right.
    dir_req_a = 4'b0001; step(); dir_req_a = 4'd0;
    check("right_moving", moving_a, 1);
    check("right_dir", dir_a, 0);
    wait_pix(0, 3'd0, "erase_seen");
    check("e0_x", x_a, 39); check("e0_y", y_a, 59); check("e0_busy", busy_a, 1);
    step(); check("e1_x", x_a, 40); check("e1_y", y_a, 59);
    step(); check("e2_x", x_a, 39); check("e2_y", y_a, 60);
    step(); check("e3_x", x_a, 40); check("e3_y", y_a, 60); check("e3_col", colour_a, 0);
    step(); check("mv_plot", plot_a, 0); check("mv_busy", busy_a, 1);
    check("mv_pos_x", pos_x_a, 39);
    step();
    check("r0_plot", plot_a, 1); check("r0_x", x_a, 40); check("r0_y", y_a, 59);
    check("r0_col", colour_a, 5); check("r0_pos_x", pos_x_a, 40); check("r0_pos_y", pos_y_a, 59);
    step(); check("r1_x", x_a, 41);
    step(); check("r2_x", x_a, 40); check("r2_y", y_a, 60);
    step(); check("r3_x", x_a, 41); check("r3_y", y_a, 60);
    step(); check("r_wait_plot", plot_a, 0);

    // Reversal is ignored; a turn down is taken and applied at the next move.
    dir_req_a = 4'b1000; step();
    check("rev_dir", dir_a, 0);
    dir_req_a = 4'b0010; step(); dir_req_a = 4'd0;
    check("down_dir", dir_a, 1);
    wait_pix(0, 3'd5, "down_draw_seen");
    check("down_x", x_a, 40); check("down_y", y_a, 60);
    check("down_pos_x", pos_x_a, 40); check("down_pos_y", pos_y_a, 60);

    // start during an erase restarts the draw at the start position.
    wait_pix(0, 3'd0, "abort_erase_seen");
    start_a = 1'b1; step(); start_a = 1'b0;
    check("abort_plot", plot_a, 1); check("abort_x", x_a, 39); check("abort_y", y_a, 59);
    check("abort_col", colour_a, 5);
    check("abort_pos_x", pos_x_a, 39); check("abort_pos_y", pos_y_a, 59);
    check("abort_moving", moving_a, 0);
    step(); check("abort_d1_x", x_a, 40);

    // Reset mid-draw, with start also high: reset wins.
    Reset = 1'b1; start_a = 1'b1; step();
    check("mrst_plot", plot_a, 0); check("mrst_pos_x", pos_x_a, 39);
    check("mrst_pos_y", pos_y_a, 59); check("mrst_dir", dir_a, 0);
    check("mrst_busy", busy_a, 0);
    Reset = 1'b0; start_a = 1'b0; step();

    // Right-hand edge on instance b.
    start_b = 1'b1; step(); start_b = 1'b0;
    check("b_d0_x", x_b, BX0); check("b_d0_plot", plot_b, 1);
    step(); check("b_d1_x", x_b, BXP2); check("b_d1_range", x_b < 8'd160, 1);
    dir_req_b = 4'b0001; step(); dir_req_b = 4'd0;
    check("b_moving", moving_b, 1);
    wait_pix(1, 3'd0, "b_erase1_seen");
    wait_pix(1, 3'd5, "b_draw1_seen");
    check("b_m1_pos_x", pos_x_b, BX1); check("b_m1_x", x_b, BX1); check("b_m1_wall", wall_b, 0);
    step(); check("b_m1_x1", x_b, BX1P); check("b_m1_range", x_b < 8'd160, 1);
    wait_pix(1, 3'd0, "b_erase2_seen");
    wait_pix(1, 3'd5, "b_draw2_seen");
    check("b_m2_pos_x", pos_x_b, BX2); check("b_m2_wall", wall_b, BHIT);
    start_b = 1'b1; step(); start_b = 1'b0;
    check("b_restart_wall", wall_b, 0); check("b_restart_pos_x", pos_x_b, BX0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
